ysyx_23060203_lsu_resp: RTL and testbench
=========================================

Name: ysyx_23060203_lsu_resp

Overview:
- Data-memory responder serving the execute stage's load/store requests.
- Accepts one request at a time over a valid/ready handshake.
- Models a configurable access latency and performs byte/halfword/word reads and writes on an internal word-organised SRAM array.
- Returns sign/zero-extended load data, or a store acknowledge, over a second valid/ready handshake.
- Sits between the EXU memory ports and the backing data memory; it replaces the current zero-latency combinational read path.

Parameters:
- DEPTH, 4096, number of 32-bit words in the internal array.
- BASE, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, cycles spent in WAIT before the access commits; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_func  in  3  RISC-V funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned: SB uses [7:0], SH uses [15:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access faulted.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP. There is no pipelining; req_ready=1 only in IDLE.
- IDLE:
  - On req_valid & req_ready, capture wen/func/addr/wdata, load cnt=LATENCY-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt!=0, decrement.
  - If cnt==0, commit the access and go to RESP.
  - Registered inputs are used; changes on req_* during WAIT are ignored.
- Commit:
  - Word index = (addr-BASE)>>2.
  - Error if addr<BASE, or (addr-BASE)>=DEPTH*4, or func is illegal. Illegal load funcs: 011, 110, 111. Illegal store funcs: anything >=011.
  - On error: no array write, rdata=0, err=1.
  - Load: select byte lane addr[1:0] or halfword lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
  - Store: byte-enable write. SB writes one lane at addr[1:0]; SH writes two lanes at addr[1]; SW writes all four. Untouched bytes are preserved.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready, clear resp_valid and go to IDLE. A new request can be accepted in the next cycle, not the same one.
- Latency: with an accept in cycle 0, resp_valid is first high in cycle LATENCY+1, so LATENCY=1 gives a response in cycle 2.
- Back-pressure: RESP may be held indefinitely; no request is accepted meanwhile.
- Reset mid-operation:
  - rst in WAIT abandons the transaction; no write occurs.
  - rst in RESP drops the response.
  - A write committed before reset remains in the array.
- Address arithmetic is 32-bit unsigned. Wrap-around below BASE is caught by the addr<BASE check.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined:
  - LH/LHU/SH with addr[0]!=0 are misaligned.
  - LW/SW with addr[1:0]!=0 are misaligned.
  - A misaligned access gives err=1, no write, rdata=0.
- Undefined:
  - No misalignment error.
  - Halfword accesses ignore addr[0].
  - Word accesses ignore addr[1:0]; the aligned word is used.

Test Plan:
- Reset, then SW 0x1234_ABCD to 0x8000_0010 with resp_ready=1, LATENCY=1: req_ready drops for cycles 1-2, resp_valid=1 in cycle 2, err=0. Then LW 0x8000_0010 returns 0x1234_ABCD.
- Byte/half store and load:
  - After the SW above, SB 0x5A to 0x8000_0013 makes the word 0x5A34_ABCD.
  - LB 0x8000_0011 returns 0xFFFF_FFAB; LBU returns 0x0000_00AB.
  - LH 0x8000_0012 returns 0x0000_5A34; LHU returns the same value.
- Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid. resp_rdata/resp_err stay stable, req_ready=0 throughout, and a req_valid pulse during that time is not accepted.
- Errors:
  - LW 0x7FFF_FFFC gives err=1, rdata=0.
  - SW at BASE+DEPTH*4 gives err=1, and the array is unchanged on readback.
  - Load func 011 gives err=1.
- LATENCY=4: accept in cycle 0 gives resp_valid in cycle 5. Assert rst in cycle 3 during a SW: resp_valid stays 0, and a later LW shows the old data.
- Misaligned LW 0x8000_0012:
  - With LSU_ALIGN_CHECK_EN: err=1.
  - Without it: err=0, returns the word at 0x8000_0010.

Source files
------------

// File: rtl/ysyx_23060203_lsu_resp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060203_lsu_resp
// Purpose  : Data-memory responder for the execute stage's load/store port.
//            It accepts one request at a time and waits LATENCY cycles. It then
//            performs a byte, halfword or word access on an internal
//            word-organised SRAM. The result goes back over a second
//            valid/ready handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH    number of 32-bit words in the array
//   BASE     byte address of word 0 (must be word aligned)
//   LATENCY  cycles spent in WAIT before the access commits (1..15)
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_wen                  1 = store, 0 = load
//   req_func                 RISC-V funct3 of the access
//   req_addr                 byte address
//   req_wdata                right-aligned store data
//   resp_valid / resp_ready  response handshake
//   resp_rdata               extended load data, 0 for stores and errors
//   resp_err                 access fault (range, illegal func, alignment)
// Build option
//   LSU_ALIGN_CHECK_EN       when defined, misaligned halfword/word accesses
//                            fault. Otherwise the low address bits that do
//                            not fit the access size are ignored.
// ============================================================================
module ysyx_23060203_lsu_resp #(
    parameter int          DEPTH   = 4096,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_SPAN     = 32'(DEPTH) << 2;
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_capture;

    logic        r_wen;
    logic [2:0]  r_func;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode. BASE is word aligned, so the low offset bits equal
    // the low address bits and can select the lane directly.
    // ------------------------------------------------------------------
    logic [31:0]        w_off;
    logic [1:0]         w_lane;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_range_err;
    logic               w_func_err;
    logic               w_misalign;
    logic               w_err;
    logic               w_commit;

    assign w_off       = r_addr - BASE;
    assign w_lane      = w_off[1:0];
    assign w_idx       = w_off[c_IDX_W+1:2];
    // addr < BASE catches addresses that wrapped in the subtraction.
    assign w_range_err = (r_addr < BASE) || (w_off >= c_SPAN);

    always_comb begin
        w_func_err = 1'b0;
        if (r_wen) begin
            w_func_err = (r_func >= 3'b011);
        end else begin
            w_func_err = (r_func == 3'b011) || (r_func[2:1] == 2'b11);
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    // func[1:0] encodes the size for every legal load and store encoding.
    always_comb begin
        w_misalign = 1'b0;
        case (r_func[1:0])
            2'b01:   w_misalign = w_lane[0];
            2'b10:   w_misalign = (w_lane != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err    = w_range_err | w_func_err | w_misalign;
    assign w_commit = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    // ------------------------------------------------------------------
    // Load path: lane selection and extension
    // ------------------------------------------------------------------
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_word = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'd0;
        case (r_func)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store path: replicate the data across lanes and enable only the
    // lanes being written, so untouched bytes keep their contents.
    // ------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wlane;
    logic        w_mem_we;

    always_comb begin
        w_be    = 4'b0000;
        w_wlane = r_wdata;
        case (r_func)
            3'b000: begin
                w_be    = 4'b0001 << w_lane;
                w_wlane = {4{r_wdata[7:0]}};
            end
            3'b001: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            3'b010: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wlane = r_wdata;
            end
        endcase
    end

    // A reset arriving in the commit cycle abandons the transaction.
    assign w_mem_we = w_commit && r_wen && !w_err && !rst;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_mem_we && w_be[b]) begin
                r_mem[w_idx][b*8 +: 8] <= w_wlane[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wen   <= 1'b0;
            r_func  <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_wen   <= req_wen;
                r_func  <= req_func;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_CNT_INIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rdata <= (r_wen || w_err) ? 32'd0 : w_load;
                r_err   <= w_err;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_lsu_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060203_lsu_resp
// Purpose  : Self-checking bench for the LSU responder. A table of directed
//            load/store vectors runs on a LATENCY=1 instance. Hand-written
//            sequences cover back-pressure, and a LATENCY=4 instance covers
//            latency and reset during WAIT.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_23060203_lsu_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=1 instance
    logic        r_rst, r_req_valid, r_req_wen, r_resp_ready;
    logic [2:0]  r_req_func;
    logic [31:0] r_req_addr, r_req_wdata;
    logic        w_req_ready, w_resp_valid, w_resp_err;
    logic [31:0] w_resp_rdata;

    // LATENCY=4 instance
    logic        r4_rst, r4_req_valid, r4_req_wen, r4_resp_ready;
    logic [2:0]  r4_req_func;
    logic [31:0] r4_req_addr, r4_req_wdata;
    logic        w4_req_ready, w4_resp_valid, w4_resp_err;
    logic [31:0] w4_resp_rdata;

    ysyx_23060203_lsu_resp #(.LATENCY(1)) u_dut (
        .clk        (clk),
        .rst        (r_rst),
        .req_valid  (r_req_valid),
        .req_ready  (w_req_ready),
        .req_wen    (r_req_wen),
        .req_func   (r_req_func),
        .req_addr   (r_req_addr),
        .req_wdata  (r_req_wdata),
        .resp_valid (w_resp_valid),
        .resp_ready (r_resp_ready),
        .resp_rdata (w_resp_rdata),
        .resp_err   (w_resp_err)
    );

    ysyx_23060203_lsu_resp #(.LATENCY(4)) u_dut4 (
        .clk        (clk),
        .rst        (r4_rst),
        .req_valid  (r4_req_valid),
        .req_ready  (w4_req_ready),
        .req_wen    (r4_req_wen),
        .req_func   (r4_req_func),
        .req_addr   (r4_req_addr),
        .req_wdata  (r4_req_wdata),
        .resp_valid (w4_resp_valid),
        .resp_ready (r4_resp_ready),
        .resp_rdata (w4_resp_rdata),
        .resp_err   (w4_resp_err)
    );

    typedef struct {
        string       name;
        logic        wen;
        logic [2:0]  func;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    localparam int c_TIMEOUT = 40;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic wen, input logic [2:0] func,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = nm; v.wen = wen; v.func = func; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Issue one transaction on the LATENCY=1 instance. Called and returns at
    // a falling edge with the DUT idle. lat counts cycles from accept to the
    // first cycle with resp_valid high. rdy_hi records any req_ready seen
    // while the transaction was in flight.
    task automatic txn1(input logic wen, input logic [2:0] func, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                        output int lat, output logic rdy_hi, output logic tmo);
        r_resp_ready = 1'b1;
        r_req_valid  = 1'b1;
        r_req_wen    = wen;
        r_req_func   = func;
        r_req_addr   = addr;
        r_req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        r_req_valid = 1'b0;
        lat    = 1;
        rdy_hi = w_req_ready;
        while (!w_resp_valid && lat < c_TIMEOUT) begin
            @(negedge clk);
            lat++;
            rdy_hi = rdy_hi | w_req_ready;
        end
        tmo = !w_resp_valid;
        rd  = w_resp_rdata;
        err = w_resp_err;
        @(negedge clk);
    endtask

    task automatic txn4(input logic wen, input logic [2:0] func, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                        output int lat, output logic tmo);
        r4_resp_ready = 1'b1;
        r4_req_valid  = 1'b1;
        r4_req_wen    = wen;
        r4_req_func   = func;
        r4_req_addr   = addr;
        r4_req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        r4_req_valid = 1'b0;
        lat = 1;
        while (!w4_resp_valid && lat < c_TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        tmo = !w4_resp_valid;
        rd  = w4_resp_rdata;
        err = w4_resp_err;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err, rdy_hi, tmo;
        int          lat;

        // ---------------- vector table ----------------
        add("sw_base10",   1, 3'b010, 32'h8000_0010, 32'h1234_ABCD, 32'h0, 0);
        add("lw_base10",   0, 3'b010, 32'h8000_0010, 32'h0, 32'h1234_ABCD, 0);
        add("sb_13",       1, 3'b000, 32'h8000_0013, 32'h0000_005A, 32'h0, 0);
        add("lw_after_sb", 0, 3'b010, 32'h8000_0010, 32'h0, 32'h5A34_ABCD, 0);
        add("lb_11",       0, 3'b000, 32'h8000_0011, 32'h0, 32'hFFFF_FFAB, 0);
        add("lbu_11",      0, 3'b100, 32'h8000_0011, 32'h0, 32'h0000_00AB, 0);
        add("lh_12",       0, 3'b001, 32'h8000_0012, 32'h0, 32'h0000_5A34, 0);
        add("lhu_12",      0, 3'b101, 32'h8000_0012, 32'h0, 32'h0000_5A34, 0);
        add("sw_14",       1, 3'b010, 32'h8000_0014, 32'h1122_3344, 32'h0, 0);
        add("sh_16",       1, 3'b001, 32'h8000_0016, 32'hFFFF_8001, 32'h0, 0);
        add("lw_after_sh", 0, 3'b010, 32'h8000_0014, 32'h0, 32'h8001_3344, 0);
        add("lh_16",       0, 3'b001, 32'h8000_0016, 32'h0, 32'hFFFF_8001, 0);
        add("lhu_14",      0, 3'b101, 32'h8000_0014, 32'h0, 32'h0000_3344, 0);
        add("lb_17",       0, 3'b000, 32'h8000_0017, 32'h0, 32'hFFFF_FF80, 0);
        add("lbu_14",      0, 3'b100, 32'h8000_0014, 32'h0, 32'h0000_0044, 0);
        add("lw_below",    0, 3'b010, 32'h7FFF_FFFC, 32'h0, 32'h0, 1);
        add("sw_word0",    1, 3'b010, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 0);
        add("sw_past_end", 1, 3'b010, 32'h8000_4000, 32'hDEAD_BEEF, 32'h0, 1);
        add("lw_word0",    0, 3'b010, 32'h8000_0000, 32'h0, 32'hCAFE_F00D, 0);
        add("sw_last",     1, 3'b010, 32'h8000_3FFC, 32'h0BAD_CAFE, 32'h0, 0);
        add("lw_last",     0, 3'b010, 32'h8000_3FFC, 32'h0, 32'h0BAD_CAFE, 0);
        add("ld_func011",  0, 3'b011, 32'h8000_0010, 32'h0, 32'h0, 1);
        add("ld_func110",  0, 3'b110, 32'h8000_0010, 32'h0, 32'h0, 1);
        add("st_func011",  1, 3'b011, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0, 1);
        add("lw_unchanged",0, 3'b010, 32'h8000_0010, 32'h0, 32'h5A34_ABCD, 0);
`ifdef LSU_ALIGN_CHECK_EN
        add("lw_mis_12",   0, 3'b010, 32'h8000_0012, 32'h0, 32'h0, 1);
        add("lh_mis_13",   0, 3'b001, 32'h8000_0013, 32'h0, 32'h0, 1);
        add("sw_mis_11",   1, 3'b010, 32'h8000_0011, 32'h0, 32'h0, 1);
        add("lw_mis_chk",  0, 3'b010, 32'h8000_0010, 32'h0, 32'h5A34_ABCD, 0);
`else
        add("lw_mis_12",   0, 3'b010, 32'h8000_0012, 32'h0, 32'h5A34_ABCD, 0);
        add("lh_mis_13",   0, 3'b001, 32'h8000_0013, 32'h0, 32'h0000_5A34, 0);
        add("sw_mis_11",   1, 3'b010, 32'h8000_0011, 32'h0102_0304, 32'h0, 0);
        add("lw_mis_chk",  0, 3'b010, 32'h8000_0010, 32'h0, 32'h0102_0304, 0);
`endif

        // ---------------- reset ----------------
        r_rst = 1'b1; r_req_valid = 1'b0; r_req_wen = 1'b0; r_req_func = 3'd0;
        r_req_addr = 32'd0; r_req_wdata = 32'd0; r_resp_ready = 1'b1;
        r4_rst = 1'b1; r4_req_valid = 1'b0; r4_req_wen = 1'b0; r4_req_func = 3'd0;
        r4_req_addr = 32'd0; r4_req_wdata = 32'd0; r4_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        r_rst  = 1'b0;
        r4_rst = 1'b0;
        chk("rst_req_ready",  {31'd0, w_req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, w_resp_valid}, 32'd0);
        chk("rst_resp_rdata", w_resp_rdata,          32'd0);
        chk("rst_resp_err",   {31'd0, w_resp_err},   32'd0);
        chk("rst4_req_ready", {31'd0, w4_req_ready}, 32'd1);
        chk("rst4_resp_valid",{31'd0, w4_resp_valid},32'd0);

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            txn1(vecs[i].wen, vecs[i].func, vecs[i].addr, vecs[i].wdata,
                 rd, err, lat, rdy_hi, tmo);
            chk({vecs[i].name, "_timeout"}, {31'd0, tmo}, 32'd0);
            chk({vecs[i].name, "_rdata"},   rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"},     {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk({vecs[i].name, "_latency"}, lat, 32'd2);
            chk({vecs[i].name, "_busy_ready"}, {31'd0, rdy_hi}, 32'd0);
            chk({vecs[i].name, "_idle_ready"}, {31'd0, w_req_ready}, 32'd1);
        end

        // ---------------- back-pressure ----------------
        r_resp_ready = 1'b0;
        r_req_valid  = 1'b1; r_req_wen = 1'b0; r_req_func = 3'b010;
        r_req_addr   = 32'h8000_0014; r_req_wdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        r_req_valid = 1'b0;
        lat = 1;
        while (!w_resp_valid && lat < c_TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 32'd2);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, w_resp_valid}, 32'd1);
            chk("bp_rdata", w_resp_rdata, 32'h8001_3344);
            chk("bp_err",   {31'd0, w_resp_err}, 32'd0);
            chk("bp_ready", {31'd0, w_req_ready}, 32'd0);
            if (k == 1) begin
                r_req_valid = 1'b1; r_req_wen = 1'b1; r_req_func = 3'b010;
                r_req_addr = 32'h8000_0014; r_req_wdata = 32'hFFFF_FFFF;
            end else begin
                r_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        r_req_valid  = 1'b0;
        r_resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", {31'd0, w_resp_valid}, 32'd0);
        chk("bp_done_ready", {31'd0, w_req_ready}, 32'd1);
        txn1(1'b0, 3'b010, 32'h8000_0014, 32'h0, rd, err, lat, rdy_hi, tmo);
        chk("bp_pulse_ignored", rd, 32'h8001_3344);

        // ---------------- LATENCY=4 instance ----------------
        txn4(1'b1, 3'b010, 32'h8000_0020, 32'h1111_1111, rd, err, lat, tmo);
        chk("l4_sw_latency", lat, 32'd5);
        chk("l4_sw_err", {31'd0, err}, 32'd0);

        // Store abandoned by a reset asserted in cycle 3 after accept.
        r4_req_valid = 1'b1; r4_req_wen = 1'b1; r4_req_func = 3'b010;
        r4_req_addr = 32'h8000_0020; r4_req_wdata = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        r4_req_valid = 1'b0;
        chk("l4_c1_valid", {31'd0, w4_resp_valid}, 32'd0);
        @(negedge clk);
        chk("l4_c2_valid", {31'd0, w4_resp_valid}, 32'd0);
        @(negedge clk);
        r4_rst = 1'b1;
        @(negedge clk);
        r4_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("l4_rst_valid", {31'd0, w4_resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("l4_rst_ready", {31'd0, w4_req_ready}, 32'd1);
        txn4(1'b0, 3'b010, 32'h8000_0020, 32'h0, rd, err, lat, tmo);
        chk("l4_old_data", rd, 32'h1111_1111);
        chk("l4_lw_latency", lat, 32'd5);
        chk("l4_lw_timeout", {31'd0, tmo}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
